// File: rtl/ex_wb_skid_reg.sv
// EX->WB pipeline register with a 2-entry skid buffer and synchronous flush.
// Optional ZERO_REG_FILTER_EN: entries destined for r0 are captured with we forced low.
module ex_wb_skid_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_we,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_we
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_result_q, main_result_d;
  logic [REG_AW-1:0]   main_rd_q, main_rd_d;
  logic                main_we_q, main_we_d;
  logic [DATA_W-1:0]   skid_result_q, skid_result_d;
  logic [REG_AW-1:0]   skid_rd_q, skid_rd_d;
  logic                skid_we_q, skid_we_d;

  logic main_vld, skid_vld, in_xfer, out_xfer, cap_we;

  assign main_vld = (state_q != EMPTY);
  assign skid_vld = (state_q == FULL);
  assign in_ready = rst_n & ~skid_vld;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = main_vld & out_ready;

`ifdef ZERO_REG_FILTER_EN
  assign cap_we = in_we & (in_rd != '0);
`else
  assign cap_we = in_we;
`endif

  assign out_valid  = main_vld;
  assign out_result = main_result_q;
  assign out_rd     = main_rd_q;
  assign out_we     = main_we_q & main_vld;

  always_comb begin
    state_d       = state_q;
    main_result_d = main_result_q;
    main_rd_d     = main_rd_q;
    main_we_d     = main_we_q;
    skid_result_d = skid_result_q;
    skid_rd_d     = skid_rd_q;
    skid_we_d     = skid_we_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_result_d = in_result;
          main_rd_d     = in_rd;
          main_we_d     = cap_we;
          state_d       = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_result_d = in_result;
          main_rd_d     = in_rd;
          main_we_d     = cap_we;
        end else if (in_xfer) begin
          // Head is stalled: park the new result behind it.
          skid_result_d = in_result;
          skid_rd_d     = in_rd;
          skid_we_d     = cap_we;
          state_d       = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_result_d = skid_result_q;
          main_rd_d     = skid_rd_q;
          main_we_d     = skid_we_q;
          state_d       = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Squash wins over any simultaneous transfer; stale data is harmless.
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= EMPTY;
      main_result_q <= '0;
      main_rd_q     <= '0;
      main_we_q     <= 1'b0;
      skid_result_q <= '0;
      skid_rd_q     <= '0;
      skid_we_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      main_result_q <= main_result_d;
      main_rd_q     <= main_rd_d;
      main_we_q     <= main_we_d;
      skid_result_q <= skid_result_d;
      skid_rd_q     <= skid_rd_d;
      skid_we_q     <= skid_we_d;
    end
  end

endmodule

// File: tb/tb_ex_wb_skid_reg.sv
// Directed self-checking bench for ex_wb_skid_reg.
module tb_ex_wb_skid_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_rd;
  logic        in_we;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;

  int checks = 0;
  int failures = 0;

`ifdef ZERO_REG_FILTER_EN
  localparam logic R0_WE_EXP = 1'b0;
`else
  localparam logic R0_WE_EXP = 1'b1;
`endif

  ex_wb_skid_reg #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_rd(in_rd), .in_we(in_we),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1ns after it, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] rd, input logic we);
    in_valid  = v;
    in_result = r;
    in_rd     = rd;
    in_we     = we;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    step(); step();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_rd", {27'b0, out_rd}, 32'd0);
    check("rst_out_we", {31'b0, out_we}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b1; #1;
    check("rst_rel_in_ready", {31'b0, in_ready}, 32'd1);

    // 1: single transfer, one-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 32'h0000FFFF, 5'd3, 1'b1);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    check("t1_out_valid", {31'b0, out_valid}, 32'd1);
    check("t1_out_result", out_result, 32'h0000FFFF);
    check("t1_out_rd", {27'b0, out_rd}, 32'd3);
    check("t1_out_we", {31'b0, out_we}, 32'd1);
    check("t1_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("t1_drain", {31'b0, out_valid}, 32'd0);

    // 2: back-to-back stream, no bubbles
    drive(1'b1, 32'hA5A5A5A5, 5'd1, 1'b1);
    step();
    check("t2_v0", {31'b0, out_valid}, 32'd1);
    check("t2_d0", out_result, 32'hA5A5A5A5);
    drive(1'b1, 32'h5A5A5A5A, 5'd2, 1'b0);
    step();
    check("t2_v1", {31'b0, out_valid}, 32'd1);
    check("t2_d1", out_result, 32'h5A5A5A5A);
    check("t2_we1", {31'b0, out_we}, 32'd0);
    drive(1'b1, 32'hFFFF0000, 5'd4, 1'b1);
    step();
    check("t2_v2", {31'b0, out_valid}, 32'd1);
    check("t2_d2", out_result, 32'hFFFF0000);
    check("t2_rd2", {27'b0, out_rd}, 32'd4);
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    step();
    check("t2_drain", {31'b0, out_valid}, 32'd0);

    // 3: stall fills skid, then drains in order
    out_ready = 1'b0;
    drive(1'b1, 32'h11111111, 5'd5, 1'b1);
    step();
    check("t3_one_in_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 32'h22222222, 5'd6, 1'b1);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    check("t3_full_in_ready", {31'b0, in_ready}, 32'd0);
    check("t3_full_head", out_result, 32'h11111111);
    step();
    check("t3_stall_hold", out_result, 32'h11111111);
    check("t3_stall_rd", {27'b0, out_rd}, 32'd5);
    out_ready = 1'b1;
    step();
    check("t3_second", out_result, 32'h22222222);
    check("t3_second_rd", {27'b0, out_rd}, 32'd6);
    check("t3_ready_back", {31'b0, in_ready}, 32'd1);
    step();
    check("t3_drain", {31'b0, out_valid}, 32'd0);

    // 4: flush in FULL with in_valid high
    out_ready = 1'b0;
    drive(1'b1, 32'h44444444, 5'd7, 1'b1); step();
    drive(1'b1, 32'h55555555, 5'd8, 1'b1); step();
    check("t4_full", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'h33333333, 5'd9, 1'b1);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    check("t4_flush_valid", {31'b0, out_valid}, 32'd0);
    check("t4_flush_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step();
    check("t4_no_33", {31'b0, out_valid}, 32'd0);

    // 4b: flush beats a real input transfer in ONE
    out_ready = 1'b0;
    drive(1'b1, 32'h66666666, 5'd10, 1'b1); step();
    flush = 1'b1;
    drive(1'b1, 32'h77777777, 5'd11, 1'b1);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    check("t4b_flush_in", {31'b0, out_valid}, 32'd0);

    // 5: reset mid-operation
    drive(1'b1, 32'hDEADBEEF, 5'd12, 1'b1); step();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    check("t5_held", out_result, 32'hDEADBEEF);
    rst_n = 1'b0; #1;
    check("t5_rst_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    check("t5_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t5_rst_result", out_result, 32'd0);
    check("t5_rst_we", {31'b0, out_we}, 32'd0);
    rst_n = 1'b1;
    step();
    check("t5_rel_ready", {31'b0, in_ready}, 32'd1);
    check("t5_rel_valid", {31'b0, out_valid}, 32'd0);

    // 6: write to r0
    out_ready = 1'b1;
    drive(1'b1, 32'h12345678, 5'd0, 1'b1);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    check("t6_valid", {31'b0, out_valid}, 32'd1);
    check("t6_result", out_result, 32'h12345678);
    check("t6_we", {31'b0, out_we}, {31'b0, R0_WE_EXP});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
